// File: rtl/stopwatch_core_if.sv
// Key-pulse / tick inputs and BCD display outputs of the stopwatch core.
// The master side drives keys and the 100 Hz level; the slave side is the core.
interface stopwatch_core_if;
    logic       clk_100HZ;
    logic       start_stop;
    logic       lap_clr;
    logic [7:0] sw_cs;
    logic [7:0] sw_sec;
    logic [7:0] sw_min;
    logic       running;
    logic       lap_hold;
    logic       ovf;

    modport master (
        output clk_100HZ, start_stop, lap_clr,
        input  sw_cs, sw_sec, sw_min, running, lap_hold, ovf
    );

    modport slave (
        input  clk_100HZ, start_stop, lap_clr,
        output sw_cs, sw_sec, sw_min, running, lap_hold, ovf
    );
endinterface

// File: rtl/stopwatch_core.sv
// Centisecond stopwatch (MM:SS.cc) counting 100 Hz divider edges in BCD,
// with start/stop, lap-freeze and clear control plus a sticky overflow flag.
module stopwatch_core #(
    parameter int unsigned MAX_MIN    = 59,
    parameter bit          SAT_ON_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_core_if.slave  sw_if
);

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_MT = DIGIT_W'(MAX_MIN / 10);
    localparam logic [DIGIT_W-1:0] MAX_MU = DIGIT_W'(MAX_MIN % 10);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_e;

    typedef struct packed {
        logic [DIGIT_W-1:0] mt;
        logic [DIGIT_W-1:0] mu;
        logic [DIGIT_W-1:0] st;
        logic [DIGIT_W-1:0] su;
        logic [DIGIT_W-1:0] ct;
        logic [DIGIT_W-1:0] cu;
    } bcd_t;

    localparam bcd_t MAX_CNT = '{mt: MAX_MT, mu: MAX_MU, st: 4'd5, su: 4'd9,
                                 ct: 4'd9, cu: 4'd9};

    state_e state_q, state_d;
    logic   prev_q;
    bcd_t   cnt_q, cnt_d;
    bcd_t   snap_q, snap_d;
    logic   ovf_q, ovf_d;
    bcd_t   disp_q, disp_d;
    logic   running_q, running_d;
    logic   lap_hold_q, lap_hold_d;

    logic   tick_c;
    logic   adv_c;
    logic   at_max_c;
    bcd_t   cnt_inc_c;

    assign tick_c   = sw_if.clk_100HZ & ~prev_q;
    assign adv_c    = tick_c & ((state_q == RUN) | (state_q == LAP));
    assign at_max_c = (cnt_q == MAX_CNT);

    // BCD ripple: cs units -> cs tens -> sec units -> sec tens (0..5) -> minutes
    always_comb begin
        cnt_inc_c = cnt_q;
        if (cnt_q.cu != 4'd9) begin
            cnt_inc_c.cu = cnt_q.cu + 4'd1;
        end else begin
            cnt_inc_c.cu = 4'd0;
            if (cnt_q.ct != 4'd9) begin
                cnt_inc_c.ct = cnt_q.ct + 4'd1;
            end else begin
                cnt_inc_c.ct = 4'd0;
                if (cnt_q.su != 4'd9) begin
                    cnt_inc_c.su = cnt_q.su + 4'd1;
                end else begin
                    cnt_inc_c.su = 4'd0;
                    if (cnt_q.st != 4'd5) begin
                        cnt_inc_c.st = cnt_q.st + 4'd1;
                    end else begin
                        cnt_inc_c.st = 4'd0;
                        if (cnt_q.mu != 4'd9) begin
                            cnt_inc_c.mu = cnt_q.mu + 4'd1;
                        end else begin
                            cnt_inc_c.mu = 4'd0;
                            cnt_inc_c.mt = cnt_q.mt + 4'd1;
                        end
                    end
                end
            end
        end
    end

    // Next state, counter, snapshot and overflow; start_stop has priority over lap_clr
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        ovf_d   = ovf_q;

        if (adv_c) begin
            if (at_max_c) begin
                ovf_d = 1'b1;
                if (!SAT_ON_OVF) begin
                    cnt_d = '0;
                end
            end else begin
                cnt_d = cnt_inc_c;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (sw_if.start_stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sw_if.start_stop) begin
                    state_d = PAUSE;
                end else if (sw_if.lap_clr) begin
                    state_d = LAP;
                    snap_d  = cnt_q;
                end
            end
            LAP: begin
                if (sw_if.start_stop) begin
                    state_d = PAUSE;
                end else if (sw_if.lap_clr) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (sw_if.start_stop) begin
                    state_d = RUN;
                end else if (sw_if.lap_clr) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Saturating overflow forces a pause, overriding any key this cycle
        if (SAT_ON_OVF && adv_c && at_max_c) begin
            state_d = PAUSE;
        end
    end

    // Outputs derived from next state so live digits move in the tick's own clock
    always_comb begin
        disp_d     = (state_d == LAP) ? snap_d : cnt_d;
        running_d  = (state_d == RUN) || (state_d == LAP);
        lap_hold_d = (state_d == LAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_q     <= 1'b0;
            cnt_q      <= '0;
            snap_q     <= '0;
            ovf_q      <= 1'b0;
            disp_q     <= '0;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= sw_if.clk_100HZ;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            ovf_q      <= ovf_d;
            disp_q     <= disp_d;
            running_q  <= running_d;
            lap_hold_q <= lap_hold_d;
        end
    end

    assign sw_if.sw_cs    = {disp_q.ct, disp_q.cu};
    assign sw_if.sw_sec   = {disp_q.st, disp_q.su};
    assign sw_if.sw_min   = {disp_q.mt, disp_q.mu};
    assign sw_if.running  = running_q;
    assign sw_if.lap_hold = lap_hold_q;
    assign sw_if.ovf      = ovf_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: two instances (saturating and wrapping, MAX_MIN=1)
// share stimulus and are compared every clock against an integer-count model.
module tb_stopwatch_core;

    localparam int MAXM = 1;
    localparam int LIM  = (MAXM * 60 + 59) * 100 + 99;

    logic clk;
    logic rst_n;
    logic hz, ss, lc;

    int n_checks;
    int n_err;

    stopwatch_core_if if_a ();
    stopwatch_core_if if_b ();

    assign if_a.clk_100HZ = hz;
    assign if_a.start_stop = ss;
    assign if_a.lap_clr    = lc;
    assign if_b.clk_100HZ = hz;
    assign if_b.start_stop = ss;
    assign if_b.lap_clr    = lc;

    stopwatch_core #(.MAX_MIN(MAXM), .SAT_ON_OVF(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .sw_if(if_a.slave));
    stopwatch_core #(.MAX_MIN(MAXM), .SAT_ON_OVF(1'b0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .sw_if(if_b.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] d_cs [2];
    logic [7:0] d_sec[2];
    logic [7:0] d_min[2];
    logic       d_run[2];
    logic       d_lap[2];
    logic       d_ovf[2];
    assign d_cs[0] = if_a.sw_cs;   assign d_cs[1] = if_b.sw_cs;
    assign d_sec[0] = if_a.sw_sec; assign d_sec[1] = if_b.sw_sec;
    assign d_min[0] = if_a.sw_min; assign d_min[1] = if_b.sw_min;
    assign d_run[0] = if_a.running;  assign d_run[1] = if_b.running;
    assign d_lap[0] = if_a.lap_hold; assign d_lap[1] = if_b.lap_hold;
    assign d_ovf[0] = if_a.ovf;      assign d_ovf[1] = if_b.ovf;

    // Model: elapsed time as an integer centisecond count, mode as a small code
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;
    int m_mode[2];
    int m_cnt [2];
    int m_snap[2];
    bit m_ovf [2];
    bit m_prev;
    bit m_sat [2];
    initial begin
        m_sat[0] = 1'b1;
        m_sat[1] = 1'b0;
    end

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_mode[i] = M_IDLE; m_cnt[i] = 0; m_snap[i] = 0; m_ovf[i] = 1'b0;
            end
        end else begin
            bit tick;
            tick = hz && !m_prev;
            m_prev = hz;
            for (int i = 0; i < 2; i++) begin
                bit counting, wrapped;
                int old;
                old = m_cnt[i];
                counting = tick && (m_mode[i] == M_RUN || m_mode[i] == M_LAP);
                wrapped = counting && (old == LIM);
                if (counting) begin
                    if (old == LIM) begin
                        m_ovf[i] = 1'b1;
                        if (!m_sat[i]) m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = old + 1;
                    end
                end
                if (ss) begin
                    if (m_mode[i] == M_RUN || m_mode[i] == M_LAP) m_mode[i] = M_PAUSE;
                    else m_mode[i] = M_RUN;
                end else if (lc) begin
                    case (m_mode[i])
                        M_RUN:   begin m_mode[i] = M_LAP; m_snap[i] = old; end
                        M_LAP:   m_mode[i] = M_RUN;
                        M_PAUSE: begin m_mode[i] = M_IDLE; m_cnt[i] = 0; m_ovf[i] = 1'b0; end
                        default: ;
                    endcase
                end
                if (wrapped && m_sat[i]) m_mode[i] = M_PAUSE;
            end
        end
    end

    task automatic cmp8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                int shown;
                shown = (m_mode[i] == M_LAP) ? m_snap[i] : m_cnt[i];
                cmp8($sformatf("u%0d_cs", i),  d_cs[i],  bcd(shown % 100));
                cmp8($sformatf("u%0d_sec", i), d_sec[i], bcd((shown / 100) % 60));
                cmp8($sformatf("u%0d_min", i), d_min[i], bcd(shown / 6000));
                cmp1($sformatf("u%0d_running", i), d_run[i],
                     (m_mode[i] == M_RUN || m_mode[i] == M_LAP));
                cmp1($sformatf("u%0d_lap_hold", i), d_lap[i], m_mode[i] == M_LAP);
                cmp1($sformatf("u%0d_ovf", i), d_ovf[i], m_ovf[i]);
            end
        end
    end

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            hz = 1'b1; @(negedge clk);
            hz = 1'b0; @(negedge clk);
        end
    endtask

    task automatic press(input logic s, input logic l);
        ss = s; lc = l; @(negedge clk);
        ss = 1'b0; lc = 1'b0; @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [7:0] mn, input logic [7:0] sc,
                       input logic [7:0] cs, input logic run, input logic lh, input logic ov,
                       input int u);
        cmp8({nm, "_min"}, d_min[u], mn);
        cmp8({nm, "_sec"}, d_sec[u], sc);
        cmp8({nm, "_cs"},  d_cs[u],  cs);
        cmp1({nm, "_running"}, d_run[u], run);
        cmp1({nm, "_lap_hold"}, d_lap[u], lh);
        cmp1({nm, "_ovf"}, d_ovf[u], ov);
    endtask

    initial begin
        n_checks = 0; n_err = 0;
        rst_n = 1'b0; hz = 1'b0; ss = 1'b0; lc = 1'b0;
        #23;
        lit("reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);

        press(1'b1, 1'b0);
        ticks(100);
        lit("t1_run", 8'h00, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        press(1'b1, 1'b0);
        ticks(5);
        lit("t1_frozen", 8'h00, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 0);

        press(1'b1, 1'b0);
        ticks(899);
        lit("t2_9s99", 8'h00, 8'h09, 8'h99, 1'b1, 1'b0, 1'b0, 0);
        ticks(1);
        lit("t2_10s", 8'h00, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        ticks(4999);
        lit("t2_59s99", 8'h00, 8'h59, 8'h99, 1'b1, 1'b0, 1'b0, 0);
        ticks(1);
        lit("t2_1m", 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0);

        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        lit("t4_clear", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        press(1'b0, 1'b1);
        lit("t4_idle_lc", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        press(1'b1, 1'b0);
        ticks(250);
        press(1'b0, 1'b1);
        lit("t3_lap", 8'h00, 8'h02, 8'h50, 1'b1, 1'b1, 1'b0, 0);
        ticks(30);
        lit("t3_hold", 8'h00, 8'h02, 8'h50, 1'b1, 1'b1, 1'b0, 0);
        press(1'b0, 1'b1);
        lit("t3_live", 8'h00, 8'h02, 8'h80, 1'b1, 1'b0, 1'b0, 0);

        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        ticks(7);
        press(1'b1, 1'b1);
        lit("t4_both", 8'h00, 8'h00, 8'h07, 1'b0, 1'b0, 1'b0, 0);

        // Tick on the same clock as RUN->PAUSE is still counted
        press(1'b1, 1'b0);
        hz = 1'b1; ss = 1'b1; @(negedge clk);
        hz = 1'b0; ss = 1'b0; @(negedge clk);
        lit("t4_tick_stop", 8'h00, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 0);

        press(1'b1, 1'b0);
        ticks(LIM - 8);
        lit("t5_max_sat", 8'h01, 8'h59, 8'h99, 1'b1, 1'b0, 1'b0, 0);
        lit("t5_max_wrap", 8'h01, 8'h59, 8'h99, 1'b1, 1'b0, 1'b0, 1);
        ticks(1);
        lit("t5_sat", 8'h01, 8'h59, 8'h99, 1'b0, 1'b0, 1'b1, 0);
        lit("t5_wrap", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 1);
        ticks(3);
        lit("t5_sat_hold", 8'h01, 8'h59, 8'h99, 1'b0, 1'b0, 1'b1, 0);
        lit("t5_wrap_run", 8'h00, 8'h00, 8'h03, 1'b1, 1'b0, 1'b1, 1);

        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        lit("t6_rst_a", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        lit("t6_rst_b", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        hz = 1'b1; ss = 1'b1; @(negedge clk);
        lit("t6_start_tick", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 0);
        hz = 1'b0; ss = 1'b0; @(negedge clk);
        ticks(1);
        lit("t6_next", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 0);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
